// File: rtl/dds_key_ctrl_pkg.sv
// Shared encodings for the DDS key controller: edit modes, waveform selects, duty reset value.
package dds_ctrl_pkg;

  localparam logic [1:0] MODE_FREQ = 2'd0;
  localparam logic [1:0] MODE_DUTY = 2'd1;
  localparam logic [1:0] MODE_WAVE = 2'd2;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  localparam int unsigned DUTY_W_DEF = 8;

  // Duty reset value is mid-scale: 2^(w-1).
  function automatic logic [31:0] duty_mid(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/dds_key_ctrl_sat_addsub.sv
// Saturating add/subtract of one step, clamped to [lo, hi]; flags whether the value moved.
module sat_addsub #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] step,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic [W-1:0] y,
  output logic         changed
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, step};
    diff = {1'b0, a} - {1'b0, step};
    y    = a;
    if (inc && !dec) begin
      y = (sum > {1'b0, hi}) ? hi : sum[W-1:0];
    end else if (dec && !inc) begin
      // diff[W] set means the subtraction went below zero
      y = (diff[W] || (diff < {1'b0, lo})) ? lo : diff[W-1:0];
    end
    changed = (y != a);
  end

endmodule

// File: rtl/dds_key_ctrl.sv
// Key-driven runtime config for the PWM/DDS core: edit-mode FSM, saturating field updates, cfg_upd strobe.
// Optional build macro STEP_ACCEL_EN enables accelerating frequency steps on repeated presses.
module dds_key_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned         PHASE_W   = 32,
  parameter logic [PHASE_W-1:0]  FREQ_INIT = 32'd85899,
  parameter logic [PHASE_W-1:0]  FREQ_STEP = 32'd8590,
  parameter logic [PHASE_W-1:0]  FREQ_MIN  = 32'd8590,
  parameter logic [PHASE_W-1:0]  FREQ_MAX  = 32'd858993,
  parameter int unsigned         DUTY_W    = DUTY_W_DEF,
  parameter logic [DUTY_W-1:0]   DUTY_STEP = 8'd16,
  parameter logic [23:0]         ACCEL_WIN = 24'd5000000,
  parameter int unsigned         ACCEL_MAX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               k0,
  input  logic               k1,
  input  logic               k2,
  output logic [1:0]         mode,
  output logic [PHASE_W-1:0] freq_word,
  output logic [DUTY_W-1:0]  duty,
  output logic [1:0]         wave_sel,
  output logic               cfg_upd
);

  localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(duty_mid(DUTY_W));

  logic               adj;
  logic               inc;
  logic               dec;
  logic [PHASE_W-1:0] freq_step;
  logic [PHASE_W-1:0] freq_nxt;
  logic               freq_chg;
  logic [DUTY_W-1:0]  duty_nxt;
  logic               duty_chg;
  logic [1:0]         wave_nxt;
  logic [1:0]         mode_nxt;

  // Simultaneous k0/k1 cancel out.
  assign adj = k0 ^ k1;
  assign inc = k0 & ~k1;
  assign dec = k1 & ~k0;

  sat_addsub #(.W(PHASE_W)) u_freq (
    .a       (freq_word),
    .step    (freq_step),
    .inc     (inc && (mode == MODE_FREQ)),
    .dec     (dec && (mode == MODE_FREQ)),
    .lo      (FREQ_MIN),
    .hi      (FREQ_MAX),
    .y       (freq_nxt),
    .changed (freq_chg)
  );

  sat_addsub #(.W(DUTY_W)) u_duty (
    .a       (duty),
    .step    (DUTY_STEP),
    .inc     (inc && (mode == MODE_DUTY)),
    .dec     (dec && (mode == MODE_DUTY)),
    .lo      ('0),
    .hi      ('1),
    .y       (duty_nxt),
    .changed (duty_chg)
  );

  always_comb begin
    wave_nxt = inc ? (wave_sel + 2'd1) : (wave_sel - 2'd1);
    case (mode)
      MODE_FREQ: mode_nxt = MODE_DUTY;
      MODE_DUTY: mode_nxt = MODE_WAVE;
      default:   mode_nxt = MODE_FREQ;
    endcase
  end

`ifdef STEP_ACCEL_EN
  localparam int unsigned SH_W = (ACCEL_MAX > 1) ? $clog2(ACCEL_MAX + 1) : 1;

  logic [23:0]     win_cnt;
  logic [SH_W-1:0] sh;
  logic [SH_W-1:0] sh_nxt;
  logic            last_dir;
  logic            last_vld;
  logic            f_press;

  assign f_press = adj && (mode == MODE_FREQ);

  always_comb begin
    sh_nxt = '0;
    if (last_vld && (last_dir == inc) && (win_cnt < ACCEL_WIN))
      sh_nxt = (sh >= SH_W'(ACCEL_MAX)) ? SH_W'(ACCEL_MAX) : sh + 1'b1;
    freq_step = FREQ_STEP << sh_nxt;
  end

  // A press coinciding with k2 still uses the accelerated step, then the history is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      sh       <= '0;
      last_dir <= 1'b0;
      last_vld <= 1'b0;
    end else if (k2) begin
      win_cnt  <= '0;
      sh       <= '0;
      last_vld <= 1'b0;
    end else if (f_press) begin
      win_cnt  <= '0;
      sh       <= sh_nxt;
      last_dir <= inc;
      last_vld <= 1'b1;
    end else if (win_cnt != ACCEL_WIN) begin
      win_cnt <= win_cnt + 24'd1;
    end else begin
      sh <= '0;
    end
  end
`else
  logic unused_accel;
  assign unused_accel = ^{ACCEL_WIN, ACCEL_MAX};
  assign freq_step    = FREQ_STEP;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= MODE_FREQ;
      freq_word <= FREQ_INIT;
      duty      <= DUTY_RST;
      wave_sel  <= WAVE_SINE;
      cfg_upd   <= 1'b0;
    end else begin
      cfg_upd <= 1'b0;
      if (adj) begin
        case (mode)
          MODE_FREQ: if (freq_chg) begin
            freq_word <= freq_nxt;
            cfg_upd   <= 1'b1;
          end
          MODE_DUTY: if (duty_chg) begin
            duty    <= duty_nxt;
            cfg_upd <= 1'b1;
          end
          MODE_WAVE: begin
            wave_sel <= wave_nxt;
            cfg_upd  <= 1'b1;
          end
          default: ;
        endcase
      end
      if (k2) mode <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed self-checking bench for dds_key_ctrl with hand-computed expectations.
module tb_dds_key_ctrl;

  logic        clk;
  logic        rst_n;
  logic        k0, k1, k2;
  logic [1:0]  mode;
  logic [31:0] freq_word;
  logic [7:0]  duty;
  logic [1:0]  wave_sel;
  logic        cfg_upd;

  int n_cmp = 0;
  int n_err = 0;

`ifdef STEP_ACCEL_EN
  localparam logic [23:0] TB_WIN = 24'd1000;
`else
  localparam logic [23:0] TB_WIN = 24'd5000000;
`endif

  dds_key_ctrl #(
    .PHASE_W   (32),
    .FREQ_INIT (32'd85899),
    .FREQ_STEP (32'd8590),
    .FREQ_MIN  (32'd8590),
    .FREQ_MAX  (32'd858993),
    .DUTY_W    (8),
    .DUTY_STEP (8'd16),
    .ACCEL_WIN (TB_WIN),
    .ACCEL_MAX (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .k0        (k0),
    .k1        (k1),
    .k2        (k2),
    .mode      (mode),
    .freq_word (freq_word),
    .duty      (duty),
    .wave_sel  (wave_sel),
    .cfg_upd   (cfg_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle key pulse; returns at the following negedge, after the sampling posedge.
  task automatic pulse(input logic a, input logic b, input logic c);
    @(negedge clk);
    k0 = a; k1 = b; k2 = c;
    @(negedge clk);
    k0 = 1'b0; k1 = 1'b0; k2 = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    k0 = 1'b0; k1 = 1'b0; k2 = 1'b0;
    rst_n = 1'b0;
    do_reset();

    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_freq", freq_word, 32'd85899);
    chk("rst_duty", 32'(duty), 32'd128);
    chk("rst_wave", 32'(wave_sel), 32'd0);
    chk("rst_upd", 32'(cfg_upd), 32'd0);

    pulse(1'b1, 1'b0, 1'b0);
    chk("f_inc", freq_word, 32'd94489);
    chk("f_inc_upd", 32'(cfg_upd), 32'd1);
    idle(1);
    chk("f_inc_upd_off", 32'(cfg_upd), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("f_dec", freq_word, 32'd85899);
    chk("f_dec_upd", 32'(cfg_upd), 32'd1);

`ifndef STEP_ACCEL_EN
    // 85899 - 8*8590 = 17179; ninth press clamps to FREQ_MIN; tenth is a no-op.
    for (int unsigned i = 0; i < 8; i++) pulse(1'b0, 1'b1, 1'b0);
    chk("f_dec8", freq_word, 32'd17179);
    pulse(1'b0, 1'b1, 1'b0);
    chk("f_min", freq_word, 32'd8590);
    chk("f_min_upd", 32'(cfg_upd), 32'd1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("f_min_hold", freq_word, 32'd8590);
    chk("f_min_noupd", 32'(cfg_upd), 32'd0);
`endif

    pulse(1'b0, 1'b0, 1'b1);
    chk("m_duty", 32'(mode), 32'd1);
    chk("m_duty_noupd", 32'(cfg_upd), 32'd0);
    for (int unsigned i = 0; i < 7; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("d_inc7", 32'(duty), 32'd240);
    pulse(1'b1, 1'b0, 1'b0);
    chk("d_sat", 32'(duty), 32'd255);
    chk("d_sat_upd", 32'(cfg_upd), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("d_hold", 32'(duty), 32'd255);
    chk("d_hold_noupd", 32'(cfg_upd), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("d_dec", 32'(duty), 32'd239);
    chk("d_dec_upd", 32'(cfg_upd), 32'd1);

    pulse(1'b0, 1'b0, 1'b1);
    chk("m_wave", 32'(mode), 32'd2);
    pulse(1'b0, 1'b1, 1'b0);
    chk("w_dec_wrap", 32'(wave_sel), 32'd3);
    chk("w_dec_upd", 32'(cfg_upd), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("w_inc_wrap", 32'(wave_sel), 32'd0);
    pulse(1'b1, 1'b1, 1'b0);
    chk("w_cancel", 32'(wave_sel), 32'd0);
    chk("w_cancel_noupd", 32'(cfg_upd), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("m_freq", 32'(mode), 32'd0);

`ifndef STEP_ACCEL_EN
    pulse(1'b1, 1'b0, 1'b1);
    chk("k0k2_freq", freq_word, 32'd17180);
`else
    pulse(1'b1, 1'b0, 1'b1);
    chk("k0k2_freq", freq_word, 32'd94489);
`endif
    chk("k0k2_mode", 32'(mode), 32'd1);
    chk("k0k2_upd", 32'(cfg_upd), 32'd1);
    chk("k0k2_duty", 32'(duty), 32'd239);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_freq", freq_word, 32'd85899);
    chk("arst_duty", 32'(duty), 32'd128);
    chk("arst_wave", 32'(wave_sel), 32'd0);
    chk("arst_upd", 32'(cfg_upd), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

`ifdef STEP_ACCEL_EN
    // Presses 100 cycles apart: steps 8590, 17180, 34360, 68720, 68720.
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_1", freq_word, 32'd94489);
    idle(98);
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_2", freq_word, 32'd111669);
    idle(98);
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_3", freq_word, 32'd146029);
    idle(98);
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_4", freq_word, 32'd214749);
    idle(98);
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_5", freq_word, 32'd283469);
    idle(1100);
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_timeout", freq_word, 32'd292059);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
